// File: rtl/lb_pixel_writer.sv
// Sprite line-buffer pixel writer: accepts 8 pixel pairs per tile row, drops
// shrunk-out pixels, and writes non-transparent pixels one per cycle.
module lb_pixel_writer #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] X_START,
  input  logic              FLIP,
  input  logic [7:0]        PAL,
  input  logic              STEP,
  input  logic              EN_A,
  input  logic              EN_B,
  input  logic [3:0]        PIX_A,
  input  logic [3:0]        PIX_B,
  output logic              READY,
  output logic              LB_WE,
  output logic [ADDR_W-1:0] LB_ADDR,
  output logic [11:0]       LB_DATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned COL_W  = 4;
  localparam int unsigned PAL_W  = 8;
  localparam int unsigned SCNT_W = 4;
  localparam int unsigned QCNT_W = 2;
  localparam logic [SCNT_W-1:0] PAIRS     = SCNT_W'(8);
  localparam logic [SCNT_W-1:0] LAST_PAIR = SCNT_W'(7);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   acnt;
  logic [ADDR_W-1:0]   acnt_next;
  logic                flip_r;
  logic [PAL_W-1:0]    pal_r;
  logic [SCNT_W-1:0]   scnt;
  logic [COL_W-1:0]    q_head;
  logic [COL_W-1:0]    q_tail;
  logic [QCNT_W-1:0]   qcnt;
  logic [QCNT_W-1:0]   push_cnt;

  // Pairs are only taken into an empty queue, so push and pop never overlap.
  always_comb READY = (state == RUN) && (qcnt == '0) && (scnt < PAIRS);

  always_comb BUSY = (state == RUN);

  always_comb acnt_next = flip_r ? (acnt - ADDR_W'(1)) : (acnt + ADDR_W'(1));

  always_comb push_cnt = {1'b0, EN_A} + {1'b0, EN_B};

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      acnt    <= '0;
      flip_r  <= 1'b0;
      pal_r   <= '0;
      scnt    <= '0;
      q_head  <= '0;
      q_tail  <= '0;
      qcnt    <= '0;
      LB_WE   <= 1'b0;
      LB_ADDR <= '0;
      LB_DATA <= '0;
      DONE    <= 1'b0;
    end else begin
      LB_WE <= 1'b0;
      DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            acnt   <= X_START;
            flip_r <= FLIP;
            pal_r  <= PAL;
            scnt   <= '0;
            qcnt   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (qcnt != '0) begin
            // Colour 0 is transparent: no write, but the address still advances.
            LB_WE   <= (q_head != '0);
            LB_ADDR <= acnt;
            LB_DATA <= {pal_r, q_head};
            acnt    <= acnt_next;
            q_head  <= q_tail;
            qcnt    <= qcnt - QCNT_W'(1);
            if ((qcnt == QCNT_W'(1)) && (scnt == PAIRS)) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end
          end else if (STEP && READY) begin
            scnt <= scnt + SCNT_W'(1);
            qcnt <= push_cnt;
            if (EN_A) begin
              q_head <= PIX_A;
              q_tail <= PIX_B;
            end else begin
              q_head <= PIX_B;
            end
            if ((push_cnt == '0) && (scnt == LAST_PAIR)) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_pixel_writer.sv
// Scoreboard bench for lb_pixel_writer: a pixel-level address/colour model
// predicts every line-buffer write; a negedge monitor checks what the DUT writes.
module tb_lb_pixel_writer;

  localparam int AW    = 9;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] x_start = '0;
  logic          flip = 1'b0;
  logic [7:0]    pal = '0;
  logic          step = 1'b0;
  logic          en_a = 1'b0;
  logic          en_b = 1'b0;
  logic [3:0]    pix_a = '0;
  logic [3:0]    pix_b = '0;
  logic          ready;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic [11:0]   lb_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  int         m_addr;
  logic       m_flip;
  logic [7:0] m_pal;

  logic [3:0] ra[8];
  logic [3:0] rb[8];
  logic       rea[8];
  logic       reb[8];

  lb_pixel_writer #(.ADDR_W(AW)) dut (
    .CLK(clk), .nRESET(n_reset), .START(start), .X_START(x_start), .FLIP(flip),
    .PAL(pal), .STEP(step), .EN_A(en_a), .EN_B(en_b), .PIX_A(pix_a), .PIX_B(pix_b),
    .READY(ready), .LB_WE(lb_we), .LB_ADDR(lb_addr), .LB_DATA(lb_data),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: every kept pixel occupies one address; only nonzero colours write.
  task automatic model_pixel(input logic [3:0] c);
    wr_t w;
    if (c != 4'd0) begin
      w.addr = AW'(m_addr);
      w.data = {m_pal, c};
      exp_q.push_back(w);
    end
    m_addr = m_flip ? ((m_addr - 1) & AMASK) : ((m_addr + 1) & AMASK);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (n_reset) begin
      if (lb_we) begin
        check("we_only_busy_or_done", 32'(busy | done), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0d:%03h required=none", lb_addr, lb_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(lb_addr), 32'(e.addr));
          check("wr_data", 32'(lb_data), 32'(e.data));
        end
      end
      if (done) check("done_with_last_write", 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic drive_junk();
    step  = 1'($urandom);
    en_a  = 1'($urandom);
    en_b  = 1'($urandom);
    pix_a = 4'($urandom);
    pix_b = 4'($urandom);
  endtask

  // smode: 0 drop START, 1 random START while running, 2 hold START high
  task automatic start_row(input int xs, input logic f, input logic [7:0] p, input int smode);
    @(negedge clk);
    x_start = AW'(xs);
    flip    = f;
    pal     = p;
    start   = 1'b1;
    m_addr  = xs;
    m_flip  = f;
    m_pal   = p;
    @(posedge clk);
    @(negedge clk);
    start   = (smode == 2) ? 1'b1 : ((smode == 1) ? 1'($urandom) : 1'b0);
    x_start = AW'($urandom);
    flip    = 1'($urandom);
    pal     = 8'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(ready), 32'd1);
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b,
                           input logic ea, input logic eb, input logic last);
    int k;
    int n;
    k = 0;
    while (!ready && k < 10) begin
      drive_junk();
      @(negedge clk);
      k++;
    end
    if (!ready) check("ready_wait", 32'(ready), 32'd1);
    step = 1'b1; pix_a = a; pix_b = b; en_a = ea; en_b = eb;
    if (ea) model_pixel(a);
    if (eb) model_pixel(b);
    n = int'(ea) + int'(eb);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    if (!last) begin
      while (!ready && k < 5) begin
        drive_junk();
        @(negedge clk);
        k++;
      end
      check("ready_latency", 32'(k), 32'(n));
    end else begin
      while (!done && k < 5) begin
        drive_junk();
        @(negedge clk);
        k++;
      end
      check("done_latency", 32'(k), 32'(n));
      check("busy_at_done", 32'(busy), 32'd0);
      check("ready_at_done", 32'(ready), 32'd0);
      start = 1'b0;
      step  = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
    step = 1'b0;
  endtask

  task automatic run_row(input int xs, input logic f, input logic [7:0] p, input int smode);
    start_row(xs, f, p, smode);
    for (int i = 0; i < 8; i++) send_pair(ra[i], rb[i], rea[i], reb[i], i == 7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lb_we"}, 32'(lb_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_lb_addr"}, 32'(lb_addr), 32'd0);
    check({tag, "_lb_data"}, 32'(lb_data), 32'd0);
  endtask

  initial begin
    #1 n_reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    // Incrementing row, colours 1..F,1
    for (int i = 0; i < 8; i++) begin
      ra[i] = 4'(2 * i + 1); rb[i] = 4'((2 * i + 2) % 16 == 0 ? 1 : 2 * i + 2);
      rea[i] = 1'b1; reb[i] = 1'b1;
    end
    run_row(10, 1'b0, 8'h25, 0);

    // Flipped row wraps below address 0
    run_row(10, 1'b1, 8'h25, 1);

    // Horizontal shrink keeping only A
    for (int i = 0; i < 8; i++) begin
      ra[i] = 4'($urandom_range(1, 15)); rb[i] = 4'($urandom_range(1, 15));
      rea[i] = 1'b1; reb[i] = 1'b0;
    end
    run_row(200, 1'b0, 8'h71, 1);

    // Transparent first pixel at 100
    ra[0] = 4'd0; rb[0] = 4'd3; rea[0] = 1'b1; reb[0] = 1'b1;
    run_row(100, 1'b0, 8'h9C, 0);

    // Everything shrunk away: no writes, address untouched
    for (int i = 0; i < 8; i++) begin rea[i] = 1'b0; reb[i] = 1'b0; end
    run_row(300, 1'b0, 8'h11, 1);
    check("acnt_unchanged", 32'(dut.acnt), 32'd300);

    // Reset after the third pair with START held high
    for (int i = 0; i < 8; i++) begin
      ra[i] = 4'($urandom_range(1, 15)); rb[i] = 4'($urandom_range(1, 15));
      rea[i] = 1'b1; reb[i] = 1'b1;
    end
    start_row(50, 1'b0, 8'h3C, 2);
    for (int i = 0; i < 3; i++) send_pair(ra[i], rb[i], rea[i], reb[i], 1'b0);
    #2 n_reset = 1'b0;
    #1 check_reset_outputs("mid_run_reset");
    exp_q.delete();
    x_start = '0; flip = 1'b0; pal = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_lb_we", 32'(lb_we), 32'd0);
    end
    m_addr = 0; m_flip = 1'b0; m_pal = 8'h5A;
    n_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_pair(ra[i], rb[i], rea[i], reb[i], i == 7);

    // Randomized rows
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) begin
        ra[i]  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        rb[i]  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        rea[i] = 1'($urandom);
        reb[i] = 1'($urandom);
      end
      run_row(int'($urandom_range(0, AMASK)), 1'($urandom), 8'($urandom), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lb_pixel_writer.md
LB_PIXEL_WRITER -- requirements
Module: lb_pixel_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, line-buffer address width.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nRESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  begin one 16-pixel sprite tile row; sampled only in IDLE.
REQ-005 SHALL have port X_START  input  ADDR_W  first line-buffer address of the row; latched on START.
REQ-006 SHALL have port FLIP  input  1  1 = addresses decrement, 0 = increment; latched on START.
REQ-007 SHALL have port PAL  input  8  palette number; latched on START.
REQ-008 SHALL have port STEP  input  1  pixel pair valid; consumed only when READY=1.
REQ-009 SHALL have ports EN_A, EN_B  input  1 each  per-pixel horizontal-shrink keep bits, from the shrink generator OUTA/OUTB.
REQ-010 SHALL have ports PIX_A, PIX_B  input  4 each  colour indices of the pair.
REQ-011 SHALL have port READY  output  1  pair can be accepted this cycle.
REQ-012 SHALL have ports LB_WE  output  1,  LB_ADDR  output  ADDR_W,  LB_DATA  output  12  registered line-buffer write port.
REQ-013 SHALL have ports BUSY  output  1  (state != IDLE) and DONE  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE and RUN only.
REQ-015 IDLE: START=1 at an edge SHALL latch X_START into address counter ACNT, latch FLIP and PAL, clear step counter SCNT (0..8) and pixel queue, enter RUN.
REQ-016 START while in RUN SHALL be ignored.
REQ-017 READY SHALL be combinational: 1 iff state=RUN, queue count=0, SCNT<8.
REQ-018 Accepted step (STEP=1 and READY=1 at edge) SHALL increment SCNT and push enabled pixels into 2-entry queue, A before B; disabled pixels pushed nothing.
REQ-019 STEP with READY=0 SHALL be ignored, no state change.
REQ-020 Each edge with queue count>0 SHALL pop head: if colour !=0 register LB_WE=1, LB_ADDR=ACNT, LB_DATA={PAL,colour}; if colour=0 LB_WE=0 (transparent).
REQ-021 Every popped pixel, transparent or not, SHALL advance ACNT by +1 (FLIP=0) or -1 (FLIP=1), modulo 2^ADDR_W.
REQ-022 Edges without a pop SHALL register LB_WE=0; LB_ADDR/LB_DATA hold.
REQ-023 Timing: pair accepted at edge N with both enabled -> writes visible after edges N+1 and N+2; READY high again after N+2; pair with one enabled -> READY after N+1; none enabled -> READY stays high after N.
REQ-024 An edge where, after its updates, SCNT=8 and queue count=0 SHALL move RUN->IDLE and register DONE=1 for exactly one cycle.
REQ-025 DONE SHALL coincide with the final pixel's LB_WE cycle; if the 8th pair had no enabled pixels, DONE SHALL appear after the accepting edge.
REQ-026 LB_WE SHALL never be 1 while in IDLE except on the DONE cycle.

Reset
REQ-027 nRESET=0 SHALL immediately force state=IDLE, READY=0, LB_WE=0, DONE=0, BUSY=0, LB_ADDR=0, LB_DATA=0, ACNT=0, SCNT=0, queue empty, regardless of CLK.
REQ-028 Reset mid-RUN SHALL abandon the row with no further writes; first START after release SHALL behave as from power-up.

Verification
REQ-029 X_START=10, FLIP=0, PAL=0x25, 8 pairs all enabled, pixels 1..F,1 -> 16 writes, addresses 10..25, data 0x251..0x25F,0x251, DONE with last write.
REQ-030 Same with FLIP=1, X_START=10 -> addresses 10 down to 507 (wrap), order A then B per pair.
REQ-031 Shrink pattern EN_A=1,EN_B=0 all pairs, pixels nonzero -> 8 writes at consecutive addresses X..X+7, READY high every 2nd cycle.
REQ-032 Pair with PIX_A=0, EN_A=1, PIX_B=3, EN_B=1 at X=100 -> no write at 100, write 0x..3 at 101.
REQ-033 All 8 pairs EN_A=EN_B=0 with STEP held high -> zero LB_WE, DONE after 8th accepting edge, ACNT unchanged.
REQ-034 nRESET low after 3rd pair, START held high during it -> LB_WE=0 at once, IDLE; after release, new START at X=0 writes from address 0.
